// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a 1-cycle-latency FIFO into a valid/ready stream through
//            a two-entry skid buffer. Optional transfer counter is enabled by
//            defining FIFO_STREAM_READER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
`ifdef FIFO_STREAM_READER_CNT_EN
    output logic [15:0]           xfer_cnt,
`endif
    output logic                  busy
);

    localparam int OUT_DEPTH = 2;

    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_rd_en;

    assign w_pop   = (r_occ != 2'd0) & m_ready;
    // Words already owned (buffered + in flight) after this cycle's pop.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = ~rst & enable & ~fifo_empty & (w_level < 3'(OUT_DEPTH));

    assign fifo_rd_en = w_rd_en;
    assign fifo_cs    = w_rd_en;
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf0;
    assign busy       = (r_occ != 2'd0) | r_inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_rd_en;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= fifo_data_out;
                    end else begin
                        r_buf1 <= fifo_data_out;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Capture queues behind whatever survives the pop.
                    if (r_occ == 2'd1) begin
                        r_buf0 <= fifo_data_out;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_data_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt <= 16'd0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of FIFO words and output stream data.
REQ-002 Parameter: OUT_DEPTH, fixed at 2, number of entries in the output skid buffer; not overridable.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: enable  input  1  high permits new FIFO reads.
REQ-006 Port: fifo_empty  input  1  FIFO empty flag.
REQ-007 Port: fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after a sampled read.
REQ-008 Port: fifo_cs  output  1  FIFO chip select.
REQ-009 Port: fifo_rd_en  output  1  FIFO read request.
REQ-010 Port: m_valid  output  1  output word available.
REQ-011 Port: m_data  output  DATA_WIDTH  output word, head of skid buffer.
REQ-012 Port: m_ready  input  1  consumer accepts m_data when m_valid is also high.
REQ-013 Port: busy  output  1  high while any read is in flight or any word is buffered.

Function
REQ-014 Block SHALL drain the upstream FIFO into a valid/ready stream, preserving word order with no loss or duplication.
REQ-015 FIFO read latency SHALL be one cycle: a read sampled at edge N SHALL be captured from fifo_data_out at edge N+1.
REQ-016 Block SHALL track occ (0..2 buffered words) and inflight (0..1 pending capture); pop = m_valid & m_ready.
REQ-017 fifo_rd_en SHALL be high iff enable=1, fifo_empty=0 and (occ + inflight - pop) < 2; combinational from these terms.
REQ-018 fifo_cs SHALL equal fifo_rd_en.
REQ-019 fifo_rd_en SHALL never be high while fifo_empty=1.
REQ-020 Steady state with FIFO non-empty and m_ready held high SHALL sustain one word per cycle.
REQ-021 m_valid SHALL be high iff occ > 0; m_data SHALL be the oldest buffered word.
REQ-022 m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 Simultaneous capture and pop SHALL leave occ unchanged; the captured word SHALL be queued behind any remaining entry.
REQ-024 A capture SHALL never occur with occ=2 and no pop; REQ-017 guarantees this, and the bench SHALL assert it.
REQ-025 Deasserting enable SHALL stop new reads only; in-flight capture SHALL complete and buffered words SHALL remain drainable.
REQ-026 busy SHALL equal (occ != 0) | (inflight != 0).

Reset
REQ-027 While rst=1: occ=0, inflight=0, m_valid=0, fifo_rd_en=0, fifo_cs=0, busy=0, m_data=0, all taking effect immediately without a clock edge.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight words; no capture SHALL occur at the first edge after release.

Configuration
REQ-029 Macro FIFO_STREAM_READER_CNT_EN: when defined, add output xfer_cnt [15:0], reset to 0, incremented on each pop, wrapping 0xFFFF->0x0000.
REQ-030 When FIFO_STREAM_READER_CNT_EN is undefined, xfer_cnt SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-031 FIFO holds 1, 10, 100, enable=1, m_ready=1 -> m_data 1, 10, 100 on three consecutive m_valid cycles; fifo_rd_en never high when fifo_empty=1.
REQ-032 FIFO holds 8 words 2**0..2**7, m_ready=0 for 10 cycles -> exactly 2 reads issued, m_valid=1, m_data=1 held; on m_ready=1, remaining words arrive one per cycle in order.
REQ-033 m_ready toggling 1,0,1,0 with FIFO continuously non-empty -> no word lost or duplicated, m_data stable during each stall.
REQ-034 enable dropped in the cycle a read is sampled -> that word is still captured and delivered, and no further fifo_rd_en occurs.
REQ-035 rst pulsed high mid-cycle with occ=2 and a read in flight -> m_valid, busy and fifo_rd_en go 0 immediately, and the first post-reset word is the next FIFO word.
REQ-036 With FIFO_STREAM_READER_CNT_EN defined and xfer_cnt preloaded by 65535 transfers -> one more pop yields xfer_cnt=0.
